cordic_result_packer: RTL and testbench

CORDIC_RESULT_PACKER -- requirements
Module: cordic_result_packer

---
 rtl/cordic_result_packer_pkg.sv | 9 +
 rtl/cordic_result_packer_fx2fp_lane.sv | 91 +++++++++
 rtl/cordic_result_packer.sv | 124 ++++++++++++
 tb/tb_cordic_result_packer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cordic_result_packer_pkg.sv
// Shared IEEE-754 single-precision field constants for the CORDIC result packer.
package cordic_result_packer_pkg;

   localparam int unsigned BIAS   = 127;
   localparam int unsigned MANT_W = 23;
   localparam int unsigned EXP_W  = 8;
   localparam logic [31:0] QNAN   = 32'h7FC0_0000;

endpackage

// File: rtl/cordic_result_packer_fx2fp_lane.sv
// One channel of fixed-point to IEEE-754 single conversion: normalize (S2), then round and pack (S3).
module fx2fp_lane
   import cordic_result_packer_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned FRAC  = WIDTH - 1,
   parameter int unsigned ROUND = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             nan_i,
   input  logic             neg_i,
   input  logic [WIDTH-1:0] mag_i,
   output logic [31:0]      fp_o
);

   localparam int unsigned PW = $clog2(WIDTH);

   logic [PW-1:0]      p, shamt;
   logic [WIDTH-1:0]   shifted;
   logic               nan2_d, nan2_q, neg2_d, neg2_q, zero2_d, zero2_q;
   logic [WIDTH-2:0]   frac2_d, frac2_q;
   logic [EXP_W-1:0]   exp2_d, exp2_q, exp_f;
   logic [WIDTH+MANT_W-1:0] ext;
   logic [MANT_W-1:0]  mant;
   logic [MANT_W:0]    mant_r;
   logic               guard, sticky, rnd;
   logic [31:0]        fp_d, fp_q;

   // S2: leading-one detect, left-align so the hidden one sits at the top bit
   always_comb begin
      p = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (mag_i[i]) p = PW'(i);
      end
      shamt   = PW'(WIDTH - 1) - p;
      shifted = mag_i << shamt;
      nan2_d  = nan2_q;
      neg2_d  = neg2_q;
      zero2_d = zero2_q;
      frac2_d = frac2_q;
      exp2_d  = exp2_q;
      if (en_i) begin
         nan2_d  = nan_i;
         neg2_d  = neg_i;
         zero2_d = !shifted[WIDTH-1];
         frac2_d = shifted[WIDTH-2:0];
         exp2_d  = EXP_W'(int'(p) + int'(BIAS) - int'(FRAC));
      end
   end

   // S3: zero-fill below narrow inputs, round-to-nearest-even on guard/sticky
   always_comb begin
      ext    = {frac2_q, {(MANT_W + 1){1'b0}}};
      mant   = ext[WIDTH+MANT_W-1 -: MANT_W];
      guard  = ext[WIDTH-1];
      sticky = |ext[WIDTH-2:0];
      rnd    = (ROUND != 0) && guard && (sticky || mant[0]);
      // A carry-out leaves the low MANT_W bits at zero, so only the exponent needs fixing
      mant_r = {1'b0, mant} + {{MANT_W{1'b0}}, rnd};
      exp_f  = exp2_q + {{(EXP_W - 1){1'b0}}, mant_r[MANT_W]};
      fp_d   = fp_q;
      if (en_i) begin
         if (nan2_q)       fp_d = QNAN;
         else if (zero2_q) fp_d = 32'h0;
         else              fp_d = {neg2_q, exp_f, mant_r[MANT_W-1:0]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nan2_q  <= 1'b0;
         neg2_q  <= 1'b0;
         zero2_q <= 1'b0;
         frac2_q <= '0;
         exp2_q  <= '0;
         fp_q    <= '0;
      end else begin
         nan2_q  <= nan2_d;
         neg2_q  <= neg2_d;
         zero2_q <= zero2_d;
         frac2_q <= frac2_d;
         exp2_q  <= exp2_d;
         fp_q    <= fp_d;
      end
   end

   assign fp_o = fp_q;

endmodule

// File: rtl/cordic_result_packer.sv
// Maps CORDIC sin/cos back to the original quadrant and packs both as IEEE-754 singles.
module cordic_result_packer
   import cordic_result_packer_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned FRAC  = WIDTH - 1,
   parameter int unsigned ROUND = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic signed [2:0] flips,
   input  logic [WIDTH-1:0]  sin_in,
   input  logic [WIDTH-1:0]  cos_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       sin_out,
   output logic [31:0]       cos_out,
   output logic              out_err
);

   logic                    en;
   logic signed [WIDTH:0]   s_ext, c_ext, sin_v, cos_v;
   logic                    flips_err;
   logic                    v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
   logic                    err1_d, err1_q, err2_d, err2_q, err3_d, err3_q;
   logic                    sneg1_d, sneg1_q, cneg1_d, cneg1_q;
   logic [WIDTH-1:0]        smag1_d, smag1_q, cmag1_d, cmag1_q;

   assign en       = !v3_q || out_ready;
   assign in_ready = en;

   // S1: quadrant map at WIDTH+1 bits so negating the most negative input cannot wrap
   always_comb begin
      s_ext     = {sin_in[WIDTH-1], sin_in};
      c_ext     = {cos_in[WIDTH-1], cos_in};
      sin_v     = s_ext;
      cos_v     = c_ext;
      flips_err = 1'b0;
      case (flips)
         3'b000:         begin sin_v = s_ext;  cos_v = c_ext[WIDTH] ? -c_ext : c_ext; end
         3'b010, 3'b110: begin sin_v = -s_ext; cos_v = -c_ext; end
         3'b001, 3'b101: begin sin_v = -c_ext; cos_v = s_ext;  end
         3'b111:         begin sin_v = c_ext;  cos_v = -s_ext; end
         default:        flips_err = 1'b1;
      endcase
   end

   always_comb begin
      v1_d    = v1_q;
      v2_d    = v2_q;
      v3_d    = v3_q;
      err1_d  = err1_q;
      err2_d  = err2_q;
      err3_d  = err3_q;
      sneg1_d = sneg1_q;
      cneg1_d = cneg1_q;
      smag1_d = smag1_q;
      cmag1_d = cmag1_q;
      if (en) begin
         v1_d    = in_valid;
         v2_d    = v1_q;
         v3_d    = v2_q;
         err1_d  = flips_err;
         err2_d  = err1_q;
         err3_d  = err2_q;
         sneg1_d = sin_v[WIDTH];
         cneg1_d = cos_v[WIDTH];
         smag1_d = WIDTH'(sin_v[WIDTH] ? -sin_v : sin_v);
         cmag1_d = WIDTH'(cos_v[WIDTH] ? -cos_v : cos_v);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         err1_q  <= 1'b0;
         err2_q  <= 1'b0;
         err3_q  <= 1'b0;
         sneg1_q <= 1'b0;
         cneg1_q <= 1'b0;
         smag1_q <= '0;
         cmag1_q <= '0;
      end else begin
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         v3_q    <= v3_d;
         err1_q  <= err1_d;
         err2_q  <= err2_d;
         err3_q  <= err3_d;
         sneg1_q <= sneg1_d;
         cneg1_q <= cneg1_d;
         smag1_q <= smag1_d;
         cmag1_q <= cmag1_d;
      end
   end

   fx2fp_lane #(.WIDTH(WIDTH), .FRAC(FRAC), .ROUND(ROUND)) u_sin_lane (
      .clk   (clk),
      .rst   (rst),
      .en_i  (en),
      .nan_i (err1_q),
      .neg_i (sneg1_q),
      .mag_i (smag1_q),
      .fp_o  (sin_out)
   );

   fx2fp_lane #(.WIDTH(WIDTH), .FRAC(FRAC), .ROUND(ROUND)) u_cos_lane (
      .clk   (clk),
      .rst   (rst),
      .en_i  (en),
      .nan_i (err1_q),
      .neg_i (cneg1_q),
      .mag_i (cmag1_q),
      .fp_o  (cos_out)
   );

   assign out_valid = v3_q;
   assign out_err   = err3_q;

endmodule

// File: tb/tb_cordic_result_packer.sv
// Directed vectors for the CORDIC result packer, with a rounding and a truncating instance side by side.
module tb_cordic_result_packer;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid, out_ready;
   logic signed [2:0] flips;
   logic [31:0]       sin_in, cos_in;
   logic              in_ready, out_valid, out_err;
   logic [31:0]       sin_out, cos_out;
   logic              t_in_ready, t_out_valid, t_out_err;
   logic [31:0]       t_sin_out, t_cos_out;

   always #5 clk = ~clk;

   cordic_result_packer #(.WIDTH(32), .FRAC(31), .ROUND(1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flips     (flips),
      .sin_in    (sin_in),
      .cos_in    (cos_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sin_out   (sin_out),
      .cos_out   (cos_out),
      .out_err   (out_err)
   );

   cordic_result_packer #(.WIDTH(32), .FRAC(31), .ROUND(0)) u_trunc (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (t_in_ready),
      .flips     (flips),
      .sin_in    (sin_in),
      .cos_in    (cos_in),
      .out_valid (t_out_valid),
      .out_ready (out_ready),
      .sin_out   (t_sin_out),
      .cos_out   (t_cos_out),
      .out_err   (t_out_err)
   );

   typedef struct {
      logic [2:0]  f;
      logic [31:0] s, c, e_sin, e_cos, t_sin, t_cos;
      logic        e_err;
   } vec_t;

   vec_t        vecs [12];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] q_sin [$];
   logic [31:0] q_cos [$];
   logic        q_err [$];
   int          bp_idx [4] = '{0, 2, 3, 4};

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic drive(input int i);
      in_valid = 1'b1;
      flips    = vecs[i].f;
      sin_in   = vecs[i].s;
      cos_in   = vecs[i].c;
   endtask

   // Called at a falling edge after driving; samples mid-cycle, then advances one clock.
   task automatic step();
      #1;
      if (out_valid && out_ready) begin
         q_sin.push_back(sin_out);
         q_cos.push_back(cos_out);
         q_err.push_back(out_err);
      end
      @(negedge clk);
   endtask

   initial begin
      //            flips   sin_in        cos_in        sin(RNE)      cos(RNE)      sin(trunc)    cos(trunc)    err
      vecs[0]  = '{3'b000, 32'h40000000, 32'h6ED9EBA1, 32'h3F000000, 32'h3F5DB3D7, 32'h3F000000, 32'h3F5DB3D7, 1'b0};
      vecs[1]  = '{3'b001, 32'h00000000, 32'h7FFFFFFF, 32'hBF800000, 32'h00000000, 32'hBF7FFFFF, 32'h00000000, 1'b0};
      vecs[2]  = '{3'b000, 32'h12345678, 32'h80000000, 32'h3E11A2B4, 32'h3F800000, 32'h3E11A2B3, 32'h3F800000, 1'b0};
      vecs[3]  = '{3'b010, 32'h80000000, 32'hC0000000, 32'h3F800000, 32'h3F000000, 32'h3F800000, 32'h3F000000, 1'b0};
      vecs[4]  = '{3'b111, 32'h20000000, 32'hE0000000, 32'hBE800000, 32'hBE800000, 32'hBE800000, 32'hBE800000, 1'b0};
      vecs[5]  = '{3'b011, 32'h40000000, 32'h40000000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 1'b1};
      vecs[6]  = '{3'b000, 32'h00000001, 32'hFFFFFFFF, 32'h30000000, 32'h30000000, 32'h30000000, 32'h30000000, 1'b0};
      vecs[7]  = '{3'b100, 32'h00000000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 1'b1};
      vecs[8]  = '{3'b110, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
      vecs[9]  = '{3'b001, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
      vecs[10] = '{3'b000, 32'h40000040, 32'h400000C0, 32'h3F000000, 32'h3F000002, 32'h3F000000, 32'h3F000001, 1'b0};
      vecs[11] = '{3'b010, 32'hC0000000, 32'h7FFFFFFF, 32'h3F000000, 32'hBF800000, 32'h3F000000, 32'hBF7FFFFF, 1'b0};

      in_valid  = 1'b0;
      out_ready = 1'b1;
      flips     = 3'b000;
      sin_in    = '0;
      cos_in    = '0;

      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sin_out", sin_out, 32'h0);
      chk("rst_cos_out", cos_out, 32'h0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // One beat at a time: out_valid must rise after exactly the third clock edge.
      for (int i = 0; i < 12; i++) begin
         drive(i);
         #1;
         chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         chk($sformatf("v%0d_lat1", i), 32'(out_valid), 32'd0);
         @(negedge clk);
         #1;
         chk($sformatf("v%0d_lat2", i), 32'(out_valid), 32'd0);
         @(negedge clk);
         #1;
         chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("v%0d_sin", i), sin_out, vecs[i].e_sin);
         chk($sformatf("v%0d_cos", i), cos_out, vecs[i].e_cos);
         chk($sformatf("v%0d_err", i), 32'(out_err), 32'(vecs[i].e_err));
         chk($sformatf("v%0d_t_valid", i), 32'(t_out_valid), 32'd1);
         chk($sformatf("v%0d_t_sin", i), t_sin_out, vecs[i].t_sin);
         chk($sformatf("v%0d_t_cos", i), t_cos_out, vecs[i].t_cos);
         chk($sformatf("v%0d_t_err", i), 32'(t_out_err), 32'(vecs[i].e_err));
      end

      // Drain, then backpressure: three in flight, a fourth held off by in_ready=0.
      @(negedge clk);
      in_valid = 1'b0;
      step();
      step();
      q_sin.delete();
      q_cos.delete();
      q_err.delete();
      drive(0);
      step();
      drive(2);
      step();
      drive(3);
      step();
      drive(4);
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
         chk($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
         chk($sformatf("bp%0d_sin_hold", k), sin_out, vecs[0].e_sin);
         chk($sformatf("bp%0d_cos_hold", k), cos_out, vecs[0].e_cos);
         step();
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) step();
      chk("bp_count", 32'(q_sin.size()), 32'd4);
      for (int k = 0; k < 4 && k < q_sin.size(); k++) begin
         chk($sformatf("bp_order%0d_sin", k), q_sin[k], vecs[bp_idx[k]].e_sin);
         chk($sformatf("bp_order%0d_cos", k), q_cos[k], vecs[bp_idx[k]].e_cos);
         chk($sformatf("bp_order%0d_err", k), 32'(q_err[k]), 32'(vecs[bp_idx[k]].e_err));
      end

      // Asynchronous reset with a result on the output and another beat in flight.
      drive(0);
      step();
      drive(1);
      step();
      in_valid = 1'b0;
      step();
      #1;
      chk("ar_pre_valid", 32'(out_valid), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      chk("ar_out_valid", 32'(out_valid), 32'd0);
      chk("ar_sin_out", sin_out, 32'h0);
      chk("ar_cos_out", cos_out, 32'h0);
      chk("ar_t_valid", 32'(t_out_valid), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("ar_in_ready", 32'(t_in_ready & in_ready), 32'd1);
      @(negedge clk);
      q_sin.delete();
      q_cos.delete();
      q_err.delete();
      for (int k = 0; k < 6; k++) step();
      chk("ar_no_stale", 32'(q_sin.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
